// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write side.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths
//   NUM_REGS                : number of architectural registers
//   reg_word_t / reg_addr_t : default-width word and index types
//   wp_state_t              : write-port sequencer states
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

    typedef logic [DATA_W_DEF-1:0] reg_word_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } wp_state_t;

endpackage

// File: rtl/regfile_write_port_decoder5to32.sv
// ----------------------------------------------------------------------------
// decoder5to32
// Binary index to one-hot enable decoder for the register file.
//   addr_i   : register index
//   en_i     : global enable; all outputs low when deasserted
//   onehot_o : one bit per register, bit addr_i set when en_i is high
// ----------------------------------------------------------------------------
module decoder5to32
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic                   en_i,
    output logic [2**ADDR_W-1:0]   onehot_o
);

    for (genvar gi = 0; gi < 2 ** ADDR_W; gi++) begin : g_dec
        assign onehot_o[gi] = en_i && (addr_i == ADDR_W'(gi));
    end

endmodule

// File: rtl/regfile_write_port.sv
// ----------------------------------------------------------------------------
// regfile_write_port
// Write side of the register file: storage, valid/ready write port with a
// one-stage commit pipeline, and a sequenced bulk clear of registers 1..N-1.
// Register 0 reads as zero and is never written.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_valid/wr_ready : write handshake; transfer when both high at a rising edge
//   wr_addr, wr_data  : destination index and data
//   clr_req           : level request to start a bulk clear (sampled in IDLE)
//   clr_busy          : bulk clear sweep in progress
//   clr_done          : one-cycle pulse after the last register is cleared
//   regs_out          : flat register bus, entry i = register i
//
// Build option:
//   REGFILE_WRITE_BYPASS_EN - when defined, a pending (accepted but not yet
//   committed) write is forwarded onto regs_out one cycle before it lands in
//   storage.
// ----------------------------------------------------------------------------
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    input  logic                                 clr_req,
    output logic                                 clr_busy,
    output logic                                 clr_done,
    output logic [2**ADDR_W-1:0][DATA_W-1:0]     regs_out
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    wp_state_t          state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic               clr_done_q;

    logic               pend_valid_q;
    logic [ADDR_W-1:0]  pend_addr_q;
    logic [DATA_W-1:0]  pend_data_q;

    logic               accept;
    logic [ADDR_W-1:0]  dec_addr;
    logic               dec_en;
    logic [DATA_W-1:0]  commit_data;
    logic [NREG-1:0]    wr_en;
    logic               unused_en0;

    // clr_req blocks acceptance in the same cycle so a clear never races a write
    assign wr_ready = (state_q == IDLE) && !clr_req;
    assign accept   = wr_valid && wr_ready;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;

    // Pending stage: holds the most recent accept for exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= accept;
            if (accept) begin
                pend_addr_q <= wr_addr;
                pend_data_q <= wr_data;
            end
        end
    end

    // Clear sequencer. The counter starts at 1 because register 0 needs no clearing;
    // the terminal compare at the top index means the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= ADDR_W'(1);
                    end
                end
                CLEAR: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q    <= IDLE;
                        clr_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // One shared decoder: the sweep owns it in CLEAR, the pending write in IDLE.
    // No write can be pending while in CLEAR because wr_ready was low on entry.
    assign dec_addr    = (state_q == CLEAR) ? cnt_q : pend_addr_q;
    assign dec_en      = (state_q == CLEAR) || pend_valid_q;
    assign commit_data = (state_q == CLEAR) ? '0 : pend_data_q;

    decoder5to32 #(
        .ADDR_W   (ADDR_W)
    ) u_dec (
        .addr_i   (dec_addr),
        .en_i     (dec_en),
        .onehot_o (wr_en)
    );

    // Register 0 has no storage; its enable is deliberately dropped
    assign unused_en0 = wr_en[0];
    assign regs_out[0] = '0;

    for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
        logic [DATA_W-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (wr_en[gi]) begin
                word_q <= commit_data;
            end
        end

`ifdef REGFILE_WRITE_BYPASS_EN
        assign regs_out[gi] = (pend_valid_q && (pend_addr_q == ADDR_W'(gi))) ? pend_data_q : word_q;
`else
        assign regs_out[gi] = word_q;
`endif
    end

endmodule

// File: tb/tb_regfile_write_port.sv
module tb_regfile_write_port;
    import regfile_pkg::*;

    localparam int NR = 32;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    wr_valid = 1'b0;
    logic                    wr_ready;
    logic [4:0]              wr_addr = '0;
    logic [31:0]             wr_data = '0;
    logic                    clr_req = 1'b0;
    logic                    clr_busy;
    logic                    clr_done;
    logic [NR-1:0][31:0]     regs_out;

    always #5 clk = ~clk;

    regfile_write_port #(
        .DATA_W   (32),
        .ADDR_W   (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .regs_out (regs_out)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural reference: committed contents, the last accepted write,
    // and how many registers the clear sweep still has to zero.
    reg_word_t m_mem [NR];
    bit        m_pv;
    int        m_pa;
    reg_word_t m_pd;
    int        m_left;
    bit        m_done;

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_mem[i] = '0;
        m_pv = 0; m_pa = 0; m_pd = '0; m_left = 0; m_done = 0;
    endfunction

    function automatic void model_edge();
        bit acc;
        acc = wr_valid && (m_left == 0) && !clr_req;
        if (m_pv && m_pa != 0) m_mem[m_pa] = m_pd;
        if (m_left > 0) begin
            m_mem[NR - m_left] = '0;
            m_left--;
            m_done = (m_left == 0);
        end else begin
            m_done = 0;
            if (clr_req) m_left = NR - 1;
        end
        m_pv = acc;
        if (acc) begin
            m_pa = int'(wr_addr);
            m_pd = wr_data;
        end
    endfunction

    function automatic reg_word_t model_view(int i);
        reg_word_t v;
        v = (i == 0) ? '0 : m_mem[i];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (m_pv && m_pa == i && i != 0) v = m_pd;
`endif
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(string tag);
        int bad;
        bad = -1;
        for (int i = 0; i < NR; i++) begin
            if (bad < 0 && regs_out[i] !== model_view(i)) bad = i;
        end
        n_vec++;
        if (bad >= 0) begin
            n_miss++;
            $display("FAIL %s regs_out[%0d]: got %h expected %h at %0t",
                     tag, bad, regs_out[bad], model_view(bad), $time);
        end
        chk({tag, " wr_ready"}, {31'd0, wr_ready}, {31'd0, (m_left == 0) && !clr_req});
        chk({tag, " clr_busy"}, {31'd0, clr_busy}, {31'd0, m_left != 0});
        chk({tag, " clr_done"}, {31'd0, clr_done}, {31'd0, m_done});
    endtask

    task automatic tick(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
        int          idx;
        logic [31:0] exp_nb;
        logic [31:0] exp_b;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int          busy_cycles;
        int          done_cnt;
        int          ready_hi;
        logic [31:0] orr;
        logic [31:0] expv;

        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5, 32'h0,        32'hDEADBEEF};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 0, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        0, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        0, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        0, 32'h0,        32'h0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        0, 32'h0,        32'h0};
        tbl[7]  = '{1'b1, 5'd3, 32'h1,        3, 32'h0,        32'h1};
        tbl[8]  = '{1'b1, 5'd3, 32'h2,        3, 32'h1,        32'h2};
        tbl[9]  = '{1'b1, 5'd7, 32'h7,        3, 32'h2,        32'h2};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        7, 32'h7,        32'h7};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        3, 32'h2,        32'h2};

        // Reset held for three cycles
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("in_reset");
        rst_n = 1'b1;
        #1;
        check_outputs("post_reset");
        chk("reset wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("reset clr_busy", {31'd0, clr_busy}, 32'd0);
        chk("reset clr_done", {31'd0, clr_done}, 32'd0);

        // Directed vectors: single write, register 0, back-to-back
        for (int k = 0; k < 12; k++) begin
            wr_valid = tbl[k].v;
            wr_addr  = tbl[k].a;
            wr_data  = tbl[k].d;
            tick("tbl");
`ifdef REGFILE_WRITE_BYPASS_EN
            expv = tbl[k].exp_b;
`else
            expv = tbl[k].exp_nb;
`endif
            $display("vec %0d: v=%0b a=%0d d=%h -> regs_out[%0d]=%h (want %h) ready=%0b",
                     k, tbl[k].v, tbl[k].a, tbl[k].d, tbl[k].idx, regs_out[tbl[k].idx], expv, wr_ready);
            chk($sformatf("tbl%0d value", k), regs_out[tbl[k].idx], expv);
            chk($sformatf("tbl%0d ready", k), {31'd0, wr_ready}, 32'd1);
        end

        // Bulk clear: load reg i = i, then clear while a write is offered
        for (int i = 1; i < NR; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 5'(i);
            wr_data  = 32'(i);
            tick("load");
        end
        wr_valid = 1'b0;
        tick("load_commit");
        chk("load reg17", regs_out[17], 32'd17);
        chk("load reg31", regs_out[31], 32'd31);

        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h00000BAD;
        #1;
        chk("clr priority wr_ready", {31'd0, wr_ready}, 32'd0);
        tick("clr_start");
        clr_req = 1'b0;
        busy_cycles = clr_busy ? 1 : 0;
        done_cnt = 0;
        ready_hi = 0;
        for (int k = 0; k < 40 && clr_busy; k++) begin
            wr_valid = 1'b1;
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            if (wr_ready) ready_hi++;
            tick("sweep");
            if (clr_busy) busy_cycles++;
            if (clr_done) done_cnt++;
        end
        wr_valid = 1'b0;
        tick("post_clr1");
        if (clr_done) done_cnt++;
        tick("post_clr2");
        orr = '0;
        for (int i = 0; i < NR; i++) orr |= regs_out[i];
        $display("clear: busy=%0d done_pulses=%0d ready_during=%0d or_all=%h",
                 busy_cycles, done_cnt, ready_hi, orr);
        chk("clr busy cycles", 32'(busy_cycles), 32'd31);
        chk("clr done pulses", 32'(done_cnt), 32'd1);
        chk("clr ready during sweep", 32'(ready_hi), 32'd0);
        chk("clr all zero", orr, 32'd0);
        chk("clr reg9 not written", regs_out[9], 32'd0);

        // Reset in the middle of a sweep (counter at 10)
        wr_valid = 1'b1; wr_addr = 5'd20; wr_data = 32'h12345678;
        tick("pre_mid");
        wr_addr = 5'd25; wr_data = 32'hCAFEF00D;
        tick("pre_mid");
        wr_valid = 1'b0;
        tick("pre_mid");
        chk("mid reg20 loaded", regs_out[20], 32'h12345678);
        clr_req = 1'b1;
        tick("mid_start");
        clr_req = 1'b0;
        repeat (9) tick("mid_sweep");
        chk("mid reg25 still set", regs_out[25], 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("mid_reset");
        chk("mid reset reg25", regs_out[25], 32'd0);
        chk("mid reset clr_busy", {31'd0, clr_busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_outputs("mid_release");
        chk("mid release wr_ready", {31'd0, wr_ready}, 32'd1);
        tick("mid_after");

        // Randomised traffic against the reference model
        for (int c = 0; c < 500; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            clr_req  = !clr_req && ($urandom_range(0, 59) == 0);
            tick("rand");
        end
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        repeat (40) tick("drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 32-entry register file: holds the storage array and drives the flat register bus consumed by the 32:1 read multiplexers.
- Accepts write requests over a valid/ready handshake, decodes the address to one-hot enables, and commits through a one-stage write pipeline.
- Provides a sequenced bulk-clear operation that zeroes registers 1..31.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  write port can accept; a transfer occurs when wr_valid && wr_ready at a rising edge.
- wr_addr  input  ADDR_W  destination register index.
- wr_data  input  DATA_W  write data.
- clr_req  input  1  start-bulk-clear request (level, sampled in IDLE).
- clr_busy  output  1  bulk clear in progress.
- clr_done  output  1  single-cycle pulse when the clear completes.
- regs_out  output  NUM_REGS x DATA_W  packed array [NUM_REGS-1:0][DATA_W-1:0]; entry i = register i; feeds read-mux inputs directly.

Behaviour:
- Reset (rst_n low, asynchronous): all storage 0, pending stage invalid, state IDLE, clr_busy 0, clr_done 0. wr_ready is 1 once rst_n is high and clr_req is 0.
- Pending stage: an accepted request at edge N is captured as pend_valid, pend_addr, pend_data. At edge N+1 it commits to storage[pend_addr]. pend_valid is overwritten by any new accept at the same edge, giving throughput of one write per cycle.
- regs_out reflects committed storage only; new data is visible after edge N+1.
- Address 0: request accepted, handshake completes normally, storage never written; regs_out[0] is constant 0.
- Back-to-back writes to the same address: the later write wins; each commits in order.
- wr_ready = (state == IDLE) && !clr_req. Combinational; clr_req has priority over a simultaneous wr_valid.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req = 1. Counter loads 1. Any pending write still commits at that same edge.
  - CLEAR: each cycle zero storage[cnt] and increment cnt. When cnt == NUM_REGS-1 that register is zeroed, clr_done pulses for the following cycle, and the FSM returns to IDLE.
  - Sweep length = NUM_REGS-1 cycles (31 at default). clr_busy = (state == CLEAR).
- wr_valid during CLEAR: ignored; wr_ready is 0, no state change.
- clr_req held high after completion starts a new sweep. The bench must drop clr_req to avoid this.
- Reset mid-sweep: immediate full reset per above; the sweep is abandoned.
- Widths: cnt is ADDR_W bits and never wraps, because the terminal compare occurs at NUM_REGS-1.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: regs_out[pend_addr] is combinationally replaced by pend_data while pend_valid is set and pend_addr != 0. New data is visible after edge N, one cycle earlier; storage timing is unchanged.
- Undefined: regs_out = storage only, as described above.

Decomposition:
- Package regfile_pkg:
  - constants DATA_W_DEF and ADDR_W_DEF;
  - NUM_REGS;
  - typedef reg_word_t (DATA_W bits);
  - typedef reg_addr_t;
  - enum wp_state_t {IDLE, CLEAR}.
- Sub-module decoder5to32: address plus enable in, one-hot NUM_REGS-bit enable out. It is instantiated once, addressed by pend_addr in IDLE and by cnt in CLEAR. Storage uses the enables.

Test Plan:
- Reset: hold rst_n low 3 cycles, release -> regs_out all 0, wr_ready=1, clr_busy=0, clr_done=0.
- Single write: addr 5, data 0xDEADBEEF accepted at edge N -> regs_out[5]=0 after N, =0xDEADBEEF after N+1 (bypass off); with bypass on, =0xDEADBEEF after N.
- Register 0: write addr 0, data 0xFFFFFFFF -> handshake completes, regs_out[0] stays 0 for 5 cycles.
- Back-to-back: addr 3 data 0x1, then addr 3 data 0x2, then addr 7 data 0x7 on consecutive cycles -> wr_ready stays 1; final regs_out[3]=0x2, regs_out[7]=0x7.
- Bulk clear: load reg i = i for i=1..31, pulse clr_req 1 cycle while wr_valid=1 -> that write is not accepted; wr_ready=0 and clr_busy=1 for 31 cycles; clr_done pulses once; all regs_out 0; writes driven during the sweep leave no effect.
- Reset mid-sweep: assert rst_n low when cnt=10 -> storage immediately 0, state IDLE; wr_ready=1 after release with clr_req low.
